// File: rtl/psum_accum_pkg.sv
// psum_accum_pkg: shared definitions for the partial-sum accumulator.
// Holds the FSM state encoding, the default geometry (lanes per row, lane
// width, rows per pass) and the width-generic saturate / ReLU helpers used
// by every lane.
package psum_accum_pkg;

  localparam int COL     = 8;
  localparam int PSUM_BW = 16;
  localparam int DEPTH   = 16;

  // Helpers work on a wide signed container so one definition serves any
  // lane width up to WIDE-1 bits.
  localparam int WIDE = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Clamp a sign-extended sum into the signed range of a bw-bit lane.
  function automatic logic signed [WIDE-1:0] sat_fn(input logic signed [WIDE-1:0] sum,
                                                    input int bw);
    logic signed [WIDE-1:0] max_v;
    logic signed [WIDE-1:0] min_v;
    logic signed [WIDE-1:0] res;
    max_v = (64'sd1 <<< (bw - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (sum > max_v) begin
      res = max_v;
    end else if (sum < min_v) begin
      res = min_v;
    end else begin
      res = sum;
    end
    return res;
  endfunction

  // Zero out negative values when en is set; pass through otherwise.
  function automatic logic signed [WIDE-1:0] relu_fn(input logic signed [WIDE-1:0] v,
                                                     input logic en);
    logic signed [WIDE-1:0] res;
    if (en && (v < 64'sd0)) begin
      res = 64'sd0;
    end else begin
      res = v;
    end
    return res;
  endfunction

endpackage

// File: rtl/psum_accum_if.sv
// psum_accum_if: bundles the row input stream and the PMEM port.
//   in_valid/in_ready/in_data : row stream from the OFIFO read side
//   OP_q                      : PMEM read data (one cycle after a read)
//   OP_d/OP_addr/OP_cen/OP_wen: PMEM write data, address, active-low enables
// master = accumulator side, slave = stream source + memory side.
interface psum_accum_if
  import psum_accum_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int aw      = $clog2(DEPTH)
);

  logic                     in_valid;
  logic                     in_ready;
  logic [col*psum_bw-1:0]   in_data;
  logic [col*psum_bw-1:0]   OP_q;
  logic [col*psum_bw-1:0]   OP_d;
  logic [aw-1:0]            OP_addr;
  logic                     OP_cen;
  logic                     OP_wen;

  modport master (
    input  in_valid, in_data, OP_q,
    output in_ready, OP_d, OP_addr, OP_cen, OP_wen
  );

  modport slave (
    output in_valid, in_data, OP_q,
    input  in_ready, OP_d, OP_addr, OP_cen, OP_wen
  );

endinterface

// File: rtl/psum_lane_add.sv
// psum_lane_add: one lane of the accumulator.
//   a, b : signed lane operands
//   relu : clamp negative results to zero
//   y    : saturated (and optionally rectified) sum
module psum_lane_add
  import psum_accum_pkg::*;
#(
  parameter int psum_bw = PSUM_BW
) (
  input  logic signed [psum_bw-1:0] a,
  input  logic signed [psum_bw-1:0] b,
  input  logic                      relu,
  output logic signed [psum_bw-1:0] y
);

  logic signed [psum_bw:0]  sum_s;
  logic signed [WIDE-1:0]   wide_s;
  logic signed [WIDE-1:0]   sat_s;
  logic signed [WIDE-1:0]   rect_s;
  logic                     unused_hi_s;

  // One guard bit makes the raw sum exact before clamping.
  always_comb begin
    sum_s  = {a[psum_bw-1], a} + {b[psum_bw-1], b};
    wide_s = WIDE'(sum_s);
    sat_s  = sat_fn(wide_s, psum_bw);
    rect_s = relu_fn(sat_s, relu);
    y      = rect_s[psum_bw-1:0];
  end

  // After clamping the upper bits are only sign copies.
  assign unused_hi_s = ^rect_s[WIDE-1:psum_bw];

endmodule

// File: rtl/psum_accum.sv
// psum_accum: accumulates rows of partial sums into PMEM, one pass of
// depth rows per start pulse.
//   clk, reset             : clock, synchronous active-high reset
//   start                  : one-cycle pulse beginning a pass
//   first_pass, last_pass,
//   relu_en                : pass modes, sampled with start
//   bus (master)           : row stream in + PMEM port out
//   busy                   : pass in progress
//   done                   : one-cycle pulse after the last write
// First pass overwrites PMEM at one row per cycle; later passes read the
// stored row, add the incoming row and write back (one row per two cycles).
module psum_accum
  import psum_accum_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int depth   = DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               first_pass,
  input  logic               last_pass,
  input  logic               relu_en,
  psum_accum_if.master       bus,
  output logic               busy,
  output logic               done
);

  localparam int             aw        = $clog2(depth);
  localparam int             rw        = col * psum_bw;
  localparam logic [aw-1:0]  last_addr = aw'(depth - 1);

  state_t          state_r;
  state_t          state_s;
  logic [aw-1:0]   addr_r;
  logic [aw-1:0]   addr_s;
  logic            first_r;
  logic            relu_r;
  logic [rw-1:0]   row_r;
  logic [rw-1:0]   sum_s;
  logic            start_take_s;
  logic            row_load_s;
  logic            rd_fire_s;
  logic            wr_fire_s;
  logic            in_ready_s;

  // Lane operands: overwrite mode passes the incoming row through (b = 0),
  // accumulate mode adds the registered row to the PMEM read data.
  for (genvar i = 0; i < col; i++) begin : g_lane
    logic signed [psum_bw-1:0] a_s;
    logic signed [psum_bw-1:0] b_s;
    assign a_s = first_r ? bus.in_data[psum_bw*i +: psum_bw] : row_r[psum_bw*i +: psum_bw];
    assign b_s = first_r ? {psum_bw{1'b0}} : bus.OP_q[psum_bw*i +: psum_bw];
    psum_lane_add #(.psum_bw(psum_bw)) u_lane (
      .a    (a_s),
      .b    (b_s),
      .relu (relu_r),
      .y    (sum_s[psum_bw*i +: psum_bw])
    );
  end

  // State, address, latched pass modes and the registered input row.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      addr_r  <= '0;
      first_r <= 1'b0;
      relu_r  <= 1'b0;
      row_r   <= '0;
    end else begin
      state_r <= state_s;
      addr_r  <= addr_s;
      if (start_take_s) begin
        first_r <= first_pass;
        relu_r  <= last_pass && relu_en;
      end
      if (row_load_s) begin
        row_r <= bus.in_data;
      end
    end
  end

  // Next-state logic and the per-cycle read/write decisions.
  always_comb begin
    state_s      = state_r;
    addr_s       = addr_r;
    start_take_s = 1'b0;
    row_load_s   = 1'b0;
    rd_fire_s    = 1'b0;
    wr_fire_s    = 1'b0;
    in_ready_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          start_take_s = 1'b1;
          addr_s       = '0;
          state_s      = first_pass ? ST_WR : ST_RD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD: begin
        in_ready_s = 1'b1;
        if (bus.in_valid) begin
          rd_fire_s  = 1'b1;
          row_load_s = 1'b1;
          state_s    = ST_WR;
        end else begin
          state_s = ST_RD;
        end
      end
      ST_WR: begin
        // Overwrite mode waits for a row here; accumulate mode always has
        // its operands ready (read data arrived this cycle).
        if (first_r) begin
          in_ready_s = 1'b1;
          wr_fire_s  = bus.in_valid;
        end else begin
          wr_fire_s = 1'b1;
        end
        if (wr_fire_s) begin
          if (addr_r == last_addr) begin
            addr_s  = '0;
            state_s = ST_DONE;
          end else begin
            addr_s  = addr_r + aw'(1);
            state_s = first_r ? ST_WR : ST_RD;
          end
        end else begin
          state_s = ST_WR;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output drive; reset masks everything so a pending write is dropped.
  always_comb begin
    bus.in_ready = 1'b0;
    bus.OP_cen   = 1'b1;
    bus.OP_wen   = 1'b1;
    bus.OP_addr  = '0;
    bus.OP_d     = '0;
    busy         = 1'b0;
    done         = 1'b0;
    if (reset) begin
      bus.OP_cen = 1'b1;
    end else begin
      bus.in_ready = in_ready_s;
      bus.OP_addr  = addr_r;
      busy         = (state_r == ST_RD) || (state_r == ST_WR);
      done         = (state_r == ST_DONE);
      if (wr_fire_s) begin
        bus.OP_cen = 1'b0;
        bus.OP_wen = 1'b0;
        bus.OP_d   = sum_s;
      end else if (rd_fire_s) begin
        bus.OP_cen = 1'b0;
      end else begin
        bus.OP_cen = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_psum_accum.sv
module tb_psum_accum;
  import psum_accum_pkg::*;

  localparam int W = COL * PSUM_BW;

  logic clk = 1'b0;
  logic reset, start, first_pass, last_pass, relu_en;
  logic busy, done;
  psum_accum_if bus ();

  psum_accum dut (
    .clk(clk), .reset(reset), .start(start), .first_pass(first_pass),
    .last_pass(last_pass), .relu_en(relu_en), .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // PMEM behavioural model plus access monitor
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] pre_val [DEPTH];
  logic [W-1:0] q_r = '0;
  bit pre_go = 1'b0;
  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, busy_cnt = 0, cyc_clk = 0;
  int log_addr[$];
  bit log_wr[$];
  int log_cyc[$];

  assign bus.OP_q = q_r;

  always @(posedge clk) begin
    cyc_clk <= cyc_clk + 1;
    if (pre_go) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= pre_val[i];
      wr_cnt <= 0; rd_cnt <= 0; done_cnt <= 0; busy_cnt <= 0;
      log_addr.delete(); log_wr.delete(); log_cyc.delete();
    end else begin
      if (!bus.OP_cen) begin
        log_addr.push_back(int'(bus.OP_addr));
        log_wr.push_back(!bus.OP_wen);
        log_cyc.push_back(cyc_clk);
        if (!bus.OP_wen) begin
          mem[bus.OP_addr] <= bus.OP_d;
          wr_cnt <= wr_cnt + 1;
        end else begin
          q_r <= mem[bus.OP_addr];
          rd_cnt <= rd_cnt + 1;
        end
      end
      if (done === 1'b1) done_cnt <= done_cnt + 1;
      if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    end
  end

  int errors = 0, checks = 0, cyc = 0;

  task automatic step();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input int a0, a1, a2, a3, a4, a5, a6, a7);
    int a[8];
    logic [W-1:0] r;
    a = '{a0, a1, a2, a3, a4, a5, a6, a7};
    r = '0;
    for (int i = 0; i < 8; i++) r[i*PSUM_BW +: PSUM_BW] = a[i][PSUM_BW-1:0];
    return r;
  endfunction

  function automatic logic [W-1:0] rep(input int v);
    return pack(v, v, v, v, v, v, v, v);
  endfunction

  // accumulate-pass access order: read k, then write k exactly one cycle later
  function automatic bit seq_ok();
    bit ok;
    ok = (log_addr.size() == 2*DEPTH);
    for (int k = 0; k < DEPTH && ok; k++) begin
      if (log_addr[2*k] != k || log_wr[2*k] || log_addr[2*k+1] != k || !log_wr[2*k+1] ||
          log_cyc[2*k+1] - log_cyc[2*k] != 1) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic preload_all(input logic [W-1:0] v);
    for (int i = 0; i < DEPTH; i++) pre_val[i] = v;
    pre_go = 1'b1; step(); pre_go = 1'b0;
  endtask

  task automatic do_start(input logic fp, input logic lp, input logic re);
    start = 1'b1; first_pass = fp; last_pass = lp; relu_en = re;
    step();
    start = 1'b0; first_pass = 1'b0; last_pass = 1'b0; relu_en = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int n = 0; n < budget; n++) begin
      if (done === 1'b1) begin at = cyc; break; end
      step();
    end
    chkn("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0, at;
    bit ok;
    reset = 1'b1; start = 1'b0; first_pass = 1'b0; last_pass = 1'b0; relu_en = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    step(); step();
    reset = 1'b0; #1;
    chkn("rst_ready", 32'(bus.in_ready), 32'd0);
    chkn("rst_cen",   32'(bus.OP_cen), 32'd1);
    chkn("rst_wen",   32'(bus.OP_wen), 32'd1);
    chkn("rst_addr",  32'(bus.OP_addr), 32'd0);
    chk ("rst_d",     bus.OP_d, '0);
    chkn("rst_busy",  32'(busy), 32'd0);
    chkn("rst_done",  32'(done), 32'd0);

    // overwrite pass: 16 rows back to back, lane value k at row k
    preload_all(rep(-1));
    do_start(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < DEPTH; k++) begin
      bus.in_valid = 1'b1; bus.in_data = rep(k); #1;
      chkn("ow_ready", 32'(bus.in_ready), 32'd1);
      chkn("ow_cenwen", 32'({bus.OP_cen, bus.OP_wen}), 32'd0);
      chkn("ow_addr", 32'(bus.OP_addr), 32'(k));
      step();
    end
    bus.in_valid = 1'b0; #1;
    chkn("ow_done", 32'(done), 32'd1);
    chkn("ow_done_cen", 32'(bus.OP_cen), 32'd1);
    chkn("ow_done_ready", 32'(bus.in_ready), 32'd0);
    step();
    chkn("ow_done_pulse", 32'(done), 32'd0);
    ok = 1'b1;
    for (int k = 0; k < DEPTH; k++) if (mem[k] !== rep(k)) ok = 1'b0;
    chkn("ow_mem", 32'(ok), 32'd1);
    chkn("ow_wr_cnt", wr_cnt, 16);
    chkn("ow_done_cnt", done_cnt, 1);

    // accumulate pass: 100 + 23, with an ignored start mid-pass
    preload_all(rep(100));
    bus.in_valid = 1'b1; bus.in_data = rep(23);
    s0 = cyc;
    do_start(1'b0, 1'b0, 1'b0);
    chkn("acc_rd_ready", 32'(bus.in_ready), 32'd1);
    chkn("acc_rd_cenwen", 32'({bus.OP_cen, bus.OP_wen}), 32'd1);
    chkn("acc_rd_addr", 32'(bus.OP_addr), 32'd0);
    chkn("acc_busy", 32'(busy), 32'd1);
    step();
    chkn("acc_wr_ready", 32'(bus.in_ready), 32'd0);
    chkn("acc_wr_cenwen", 32'({bus.OP_cen, bus.OP_wen}), 32'd0);
    chk ("acc_wr_d", bus.OP_d, rep(123));
    step(); step(); step();
    start = 1'b1; first_pass = 1'b1;
    step();
    start = 1'b0; first_pass = 1'b0;
    wait_done(60, at);
    chkn("acc_done_cycle", at - s0, 33);
    step();
    bus.in_valid = 1'b0;
    chkn("acc_busy_cnt", busy_cnt, 32);
    chkn("acc_rd_cnt", rd_cnt, 16);
    chkn("acc_wr_cnt", wr_cnt, 16);
    chkn("acc_seq", 32'(seq_ok()), 32'd1);
    ok = 1'b1;
    for (int k = 0; k < DEPTH; k++) if (mem[k] !== rep(123)) ok = 1'b0;
    chkn("acc_mem", 32'(ok), 32'd1);

    // saturation; relu_en alone (last_pass=0) must not rectify
    preload_all(pack(32000, -32000, 32000, -32000, 100, -100, 0, 0));
    bus.in_valid = 1'b1; bus.in_data = pack(1000, -1000, 767, -768, -50, 50, -1, 1);
    do_start(1'b0, 1'b0, 1'b1);
    wait_done(60, at);
    step();
    chk("sat_row0",  mem[0],  pack(32767, -32768, 32767, -32768, 50, -50, -1, 1));
    chk("sat_row15", mem[15], pack(32767, -32768, 32767, -32768, 50, -50, -1, 1));

    // ReLU on the last accumulate pass
    preload_all(pack(-5, 5, -5, 5, 0, -1, 32767, -32768));
    bus.in_data = pack(2, 2, 5, -10, 0, 1, 1, -1);
    do_start(1'b0, 1'b1, 1'b1);
    wait_done(60, at);
    step();
    chk("relu_row0", mem[0], pack(0, 7, 0, 0, 0, 0, 32767, 0));
    chk("relu_row7", mem[7], pack(0, 7, 0, 0, 0, 0, 32767, 0));

    // ReLU in overwrite mode
    preload_all(rep(9));
    bus.in_data = pack(-3, 4, -32768, 0, 1, -1, 100, -100);
    do_start(1'b1, 1'b1, 1'b1);
    wait_done(30, at);
    step();
    bus.in_valid = 1'b0;
    chk("ow_relu_row3", mem[3], pack(0, 4, 0, 0, 1, 0, 100, 0));

    // gapped input: one row every third cycle
    for (int k = 0; k < DEPTH; k++) pre_val[k] = rep(10*k);
    pre_go = 1'b1; step(); pre_go = 1'b0;
    do_start(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < DEPTH; k++) begin
      step(); step();
      bus.in_valid = 1'b1; bus.in_data = rep(k + 1); #1;
      chkn("gap_ready", 32'(bus.in_ready), 32'd1);
      step();
      bus.in_valid = 1'b0;
    end
    wait_done(10, at);
    step();
    chkn("gap_rd_cnt", rd_cnt, 16);
    chkn("gap_wr_cnt", wr_cnt, 16);
    chkn("gap_seq", 32'(seq_ok()), 32'd1);
    ok = 1'b1;
    for (int k = 0; k < DEPTH; k++) if (mem[k] !== rep(11*k + 1)) ok = 1'b0;
    chkn("gap_mem", 32'(ok), 32'd1);

    // reset after the row-7 write aborts the pass
    preload_all(rep(555));
    do_start(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      bus.in_valid = 1'b1; bus.in_data = rep(1000 + k);
      step();
    end
    bus.in_data = rep(1008);
    reset = 1'b1; #1;
    chkn("rst_mid_cen", 32'(bus.OP_cen), 32'd1);
    step();
    reset = 1'b0; #1;
    chkn("rst_after_cen", 32'(bus.OP_cen), 32'd1);
    chkn("rst_after_busy", 32'(busy), 32'd0);
    chkn("rst_after_ready", 32'(bus.in_ready), 32'd0);
    step();
    chkn("rst_wr_cnt", wr_cnt, 8);
    chk ("rst_row7", mem[7], rep(1007));
    ok = 1'b1;
    for (int k = 8; k < DEPTH; k++) if (mem[k] !== rep(555)) ok = 1'b0;
    chkn("rst_untouched", 32'(ok), 32'd1);

    // restart after reset begins at address 0
    bus.in_valid = 1'b1; bus.in_data = rep(1);
    do_start(1'b0, 1'b0, 1'b0);
    chkn("restart_addr", 32'(bus.OP_addr), 32'd0);
    chkn("restart_cenwen", 32'({bus.OP_cen, bus.OP_wen}), 32'd1);
    wait_done(60, at);
    step();
    bus.in_valid = 1'b0;
    chk("restart_row0", mem[0], rep(1001));
    chk("restart_row8", mem[8], rep(556));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/psum_accum.md
PSUM_ACCUM -- requirements
Module: psum_accum

Interface
REQ-001 Parameter: col, 8, lanes per row.
REQ-002 Parameter: psum_bw, 16, signed lane width in bits.
REQ-003 Parameter: depth, 16, rows per pass (PMEM entries); addresses 0..depth-1.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse; begins one pass of depth rows.
REQ-007 first_pass  input  1  sampled with start; 1 = overwrite PMEM, no read.
REQ-008 last_pass  input  1  sampled with start; 1 = apply ReLU on write if relu_en.
REQ-009 relu_en  input  1  sampled with start; ReLU enable.
REQ-010 in_valid  input  1  in_data holds a valid row (OFIFO read side).
REQ-011 in_ready  output  1  row accepted in any cycle where in_valid && in_ready.
REQ-012 in_data  input  col*psum_bw  row; lane i = bits [psum_bw*i +: psum_bw], signed.
REQ-013 OP_q  input  col*psum_bw  PMEM read data, valid the cycle after a read is issued.
REQ-014 OP_d  output  col*psum_bw  PMEM write data.
REQ-015 OP_addr  output  4  PMEM address.
REQ-016 OP_cen  output  1  PMEM chip enable, active-low.
REQ-017 OP_wen  output  1  PMEM write enable, active-low (0 = write, 1 = read).
REQ-018 busy  output  1  high from the cycle after start until done.
REQ-019 done  output  1  one-cycle pulse after the last write of a pass.

Function
REQ-020 FSM states: IDLE, RD (read issued), WR (write issued), DONE.
REQ-021 IDLE: in_ready=0, OP_cen=1; start -> latch modes, addr=0, go RD (or WR-direct if first_pass).
REQ-022 Accumulate mode (first_pass=0): in_ready=1 in RD; on accept, drive OP_cen=0, OP_wen=1, OP_addr=addr and register in_data; next cycle go WR.
REQ-023 WR: in_ready=0; OP_cen=0, OP_wen=0, OP_addr=addr, OP_d = lane-wise sat(OP_q + registered row).
REQ-024 Accumulate throughput: one row per 2 cycles; read-to-write latency exactly 1 cycle.
REQ-025 Overwrite mode (first_pass=1): in_ready=1 every active cycle; on accept, write in the same cycle with OP_d = in_data (after ReLU if enabled), OP_cen=0, OP_wen=0; 1 row/cycle.
REQ-026 In RD with no in_valid: OP_cen=1, state holds, addr holds.
REQ-027 Saturation: each lane sum computed in psum_bw+1 bits and clamped to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
REQ-028 ReLU (last_pass && relu_en): negative lane values written as 0, applied after saturation.
REQ-029 addr increments after each write; after the write at addr=depth-1, go DONE; addr wraps to 0.
REQ-030 DONE: done=1 for exactly one cycle, OP_cen=1, in_ready=0, then IDLE.
REQ-031 start while busy is ignored; modes are not re-sampled.
REQ-032 OP_cen=1 in every cycle not specified above; no PMEM access in IDLE or DONE.

Reset
REQ-033 Reset forces IDLE, addr=0, latched modes=0, in_ready=0, busy=0, done=0, OP_cen=1, OP_wen=1, OP_addr=0, OP_d=0.
REQ-034 Reset mid-pass aborts the pass; any pending write is dropped; no PMEM access in the cycle after reset.

Structure
REQ-035 Shared package holds the FSM state enum, the col/psum_bw/depth defaults and the saturate/ReLU functions.
REQ-036 One sub-module, psum_lane_add: one lane, saturating add plus ReLU, instantiated col times.

Verification
REQ-037 first_pass=1, 16 back-to-back rows with lane value k at row k -> 16 writes in 16 cycles, PMEM[k] lanes = k, done pulses once.
REQ-038 first_pass=0, PMEM all 100, input all 23 -> read/write alternate, PMEM = 123, done after 32 active cycles.
REQ-039 Saturation: PMEM 32000 + in 1000 -> 32767; PMEM -32000 + in -1000 -> -32768.
REQ-040 last_pass=1, relu_en=1, PMEM -5 + in 2 -> written 0; PMEM 5 + in 2 -> 7.
REQ-041 Gapped in_valid (every third cycle) -> no extra PMEM accesses, addresses 0..15 in order, final contents correct.
REQ-042 Reset asserted after row 7 write -> OP_cen=1 next cycle, busy=0, PMEM rows 8..15 untouched; new start restarts at addr 0.
